dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder serving load/store requests issued by the MEM pipeline stage. Accepts one request at a time over a valid/ready channel and drives a fixed-latency synchronous SRAM port. Performs byte/half/word lane steering and load sign/zero extension, then returns exactly one response per request (loads and stores) over a second valid/ready channel toward MEM/WB.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LATENCY, 1, SRAM read latency in cycles after the mem_en cycle; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- mem_en  out  1  SRAM access strobe
- mem_wstrb  out  4  byte write enables, 0000 for reads
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  SRAM read word
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data, 0 for stores
- rsp_err  out  1  request rejected (alignment/size)

## Operation
- FSM states IDLE, ACCESS, RESP. Reset state IDLE.
- req_ready = (state == IDLE). Handshake fires when req_valid & req_ready; all request fields registered on that edge; IDLE -> ACCESS (or -> RESP on error).
- ACCESS: counter cnt starts at 0. mem_en = 1 only when cnt == 0; mem_addr/mem_wstrb/mem_wdata driven from registers in that cycle, 0 otherwise.
- Store: mem_wdata = byte replicated x4 (byte), half replicated x2 (half), word as-is. mem_wstrb = 0001<<addr[1:0] (byte), 0011<<(addr[1]*2) (half), 1111 (word). After the mem_en cycle -> RESP, rsp_rdata = 0.
- Load: mem_wstrb = 0000. cnt increments each ACCESS cycle; at cnt == LATENCY mem_rdata is captured, selected by addr[1:0] (byte) or addr[1] (half), extended per req_unsigned, -> RESP.
- RESP: rsp_valid = 1, rsp_rdata/rsp_err held stable until rsp_valid & rsp_ready, then -> IDLE. No new request accepted in the same cycle.
- Response order equals request order (single outstanding).

## Timing
- Reset values: req_ready 0 during reset then 1 in IDLE; mem_en 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- Load, LATENCY=L: accept at cycle 0, mem_en cycle 1, capture cycle 1+L, rsp_valid from cycle 2+L.
- Store: accept cycle 0, mem_en cycle 1, rsp_valid from cycle 2.
- Error: accept cycle 0, rsp_valid from cycle 1, mem_en never asserted.
- Back-to-back minimum spacing: load L+3 cycles, store 3 cycles, given rsp_ready = 1.
- rsp_ready low: RESP held indefinitely, outputs stable, req_ready stays 0.
- Reset asserted mid-operation: immediately IDLE, mem_en and rsp_valid drop asynchronously, in-flight request discarded with no response.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> error path; rsp_err=1, rsp_rdata=0, no SRAM access, no write.
- Not defined: no checks; size 11 treated as word; half ignores addr[0], word ignores addr[1:0]; rsp_err tied 0.

## Test plan
- Reset mid-ACCESS (LATENCY=3, load at cycle 0, reset cycle 2) -> mem_en/rsp_valid 0 immediately, no response after release, req_ready 1 first cycle after reset deasserts.
- Store byte 0xA5 to addr 0x1003 -> mem_addr 0x400, mem_wstrb 1000, mem_wdata 0xA5A5A5A5, rsp_valid at cycle 2, rsp_rdata 0, rsp_err 0.
- Load half signed from addr 0x0002, mem_rdata 0x8001_1234, LATENCY=1 -> rsp_rdata 0xFFFF8001 at cycle 3; same with req_unsigned=1 -> 0x00008001.
- Load byte addr 0x0001, mem_rdata 0x0000_7F00, LATENCY=4, rsp_ready low 5 cycles -> rsp_valid from cycle 6, rsp_rdata 0x0000007F held stable, req_ready 0 until handshake.
- With DMEM_ALIGN_CHECK_EN, word store addr 0x0006 -> rsp_err 1 at cycle 1, mem_en never 1; without macro -> mem_addr 0x1, mem_wstrb 1111, rsp_err 0.
- 20 random back-to-back load/store requests against a reference memory model -> all responses in order, data matches, exactly one response each.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: single-outstanding load/store front end for a fixed-latency SRAM.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word and reserved-size requests.
module dmem_resp #(
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_en,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              r_we;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              req_fire;
    logic              req_bad;
    logic              access_first;
    logic              load_done;
    logic [3:0]        strb;
    logic [31:0]       wdata_lanes;
    logic [31:0]       load_ext;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    // Gated by reset so the channel reads not-ready while reset is held.
    assign req_ready = (state == IDLE) && !reset;
    assign req_fire  = req_valid && req_ready;

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_bad = (req_size == 2'b11)
                  || (req_size == SIZE_HALF && req_addr[0])
                  || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
`else
    assign req_bad = 1'b0;
`endif

    assign access_first = (state == ACCESS) && (cnt == 4'd0);
    assign load_done    = (state == ACCESS) && !r_we && (cnt == 4'(LATENCY));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = req_bad ? RESP : ACCESS;
            ACCESS:  if (r_we || load_done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 4'd0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else if (req_fire) begin
            cnt        <= 4'd0;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            rdata_q    <= 32'd0;
            err_q      <= req_bad;
        end else if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
            if (load_done) rdata_q <= load_ext;
        end
    end

    // Lane steering; size 11 only reaches here when checking is off and then behaves as word.
    always_comb begin
        strb        = 4'b1111;
        wdata_lanes = r_wdata;
        ld_byte     = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        ld_half     = mem_rdata[{r_addr[1], 4'b0000} +: 16];
        load_ext    = mem_rdata;
        case (r_size)
            SIZE_BYTE: begin
                strb        = 4'b0001 << r_addr[1:0];
                wdata_lanes = {4{r_wdata[7:0]}};
                load_ext    = r_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SIZE_HALF: begin
                strb        = 4'b0011 << {r_addr[1], 1'b0};
                wdata_lanes = {2{r_wdata[15:0]}};
                load_ext    = r_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

    assign mem_en    = access_first;
    assign mem_wstrb = (access_first && r_we) ? strb : 4'b0000;
    assign mem_addr  = access_first ? r_addr[ADDR_W-1:2] : '0;
    assign mem_wdata = access_first ? wdata_lanes : 32'd0;

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: SRAM model with read latency, reference memory and response scoreboard.
// Expectations follow DMEM_ALIGN_CHECK_EN when the bench is compiled with it.
module tb_dmem_resp;

    localparam int ADDR_W    = 32;
    localparam int LAT       = 3;
    localparam int MEM_WORDS = 2048;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              mem_en;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [31:0] ref_mem [MEM_WORDS];

    logic        mem_init;
    logic [31:0] sram    [MEM_WORDS];
    logic [31:0] rd_pipe [LAT];

    dmem_resp #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_en       (mem_en),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return {16'(i) ^ 16'hA5C3, ~16'(i)};
    endfunction

    // SRAM: read data appears LAT cycles after the strobe; any other cycle shows a poison value.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_word(i);
        end else if (mem_en && mem_wstrb != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) sram[mem_addr[10:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd_pipe[0] <= (mem_en && mem_wstrb == 4'b0000) ? sram[mem_addr[10:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, output logic bad);
        exp_t        e;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          idx;
        idx = int'(addr[12:2]);
        bad = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`endif
        e.err   = bad;
        e.rdata = 32'd0;
        w       = ref_mem[idx];
        if (!bad && we) begin
            case (size)
                2'b00:   w[8*int'(addr[1:0]) +: 8] = wdata[7:0];
                2'b01:   if (addr[1]) w[31:16] = wdata[15:0]; else w[15:0] = wdata[15:0];
                default: w = wdata;
            endcase
            ref_mem[idx] = w;
        end else if (!bad) begin
            case (size)
                2'b00: begin
                    b = w[8*int'(addr[1:0]) +: 8];
                    e.rdata = {{24{b[7] & ~uns}}, b};
                end
                2'b01: begin
                    h = addr[1] ? w[31:16] : w[15:0];
                    e.rdata = {{16{h[15] & ~uns}}, h};
                end
                default: e.rdata = w;
            endcase
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, output logic bad);
        check("req_ready_before_send", 32'(req_ready), 32'd1);
        model_req(we, size, uns, addr, wdata, bad);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
    endtask

    // Called in the cycle after acceptance (latency 1); compares the first response cycle.
    task automatic collect(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        end
        if (rsp_ready) begin
            tick();
            check({tag, "_single_rsp"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        logic        bad;
        int          stray;
        int          n_rsp;
        logic        we;
        logic [1:0]  size;

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        reset        = 1'b1;
        mem_init     = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset    = 1'b0;
        mem_init = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        tick();

        // Reset in the middle of a load's ACCESS phase.
        send(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'd0, bad);
        check("midrst_mem_en_c1", 32'(mem_en), 32'd1);
        check("midrst_mem_addr_c1", 32'(mem_addr), 32'h10);
        check("midrst_mem_wstrb_c1", 32'(mem_wstrb), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_req_ready_release", 32'(req_ready), 32'd1);
        exp_q.delete();
        stray = 0;
        repeat (LAT + 3) begin
            tick();
            if (rsp_valid || mem_en) stray++;
        end
        check("midrst_no_response", 32'(stray), 32'd0);

        // Reset while a response is waiting: rsp_valid must drop without a clock edge.
        rsp_ready = 1'b0;
        send(1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'h1122_3344, bad);
        tick();
        check("resprst_valid_before", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("resprst_valid_async", 32'(rsp_valid), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        exp_q.delete();
        rsp_ready = 1'b1;

        // Byte store with lane replication and strobe on lane 3.
        send(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h1234_56A5, bad);
        check("stb_mem_en", 32'(mem_en), 32'd1);
        check("stb_mem_addr", 32'(mem_addr), 32'h400);
        check("stb_mem_wstrb", 32'(mem_wstrb), 32'b1000);
        check("stb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("stb_rsp_valid_c1", 32'(rsp_valid), 32'd0);
        collect("stb", 2);

        // Half loads, signed then unsigned, from the upper half of word 0.
        send(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h8001_1234, bad);
        collect("stw_pre", 2);
        send(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'd0, bad);
        check("ldh_mem_en", 32'(mem_en), 32'd1);
        check("ldh_mem_wstrb", 32'(mem_wstrb), 32'd0);
        collect("ldh_signed", 2 + LAT);
        send(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'd0, bad);
        collect("ldh_unsigned", 2 + LAT);

        // Byte load with the consumer stalling for 5 cycles.
        send(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0000_7F00, bad);
        collect("stw_pre2", 2);
        rsp_ready = 1'b0;
        send(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'd0, bad);
        collect("ldb_stall", 2 + LAT);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        stray = 0;
        repeat (5) begin
            tick();
            if (!rsp_valid || rsp_rdata !== 32'h0000_007F || rsp_err || req_ready) stray++;
        end
        check("ldb_stall_hold", 32'(stray), 32'd0);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        rsp_ready = 1'b1;
        tick();
        check("ldb_stall_release_valid", 32'(rsp_valid), 32'd0);
        check("ldb_stall_release_ready", 32'(req_ready), 32'd1);

        // Misaligned word store, then read back the word it would touch.
        send(1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'hCAFE_F00D, bad);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_mem_en", 32'(mem_en), 32'd0);
        check("mis_rsp_err_c1", 32'(rsp_err), 32'd1);
        collect("mis_st", 1);
`else
        check("mis_mem_en", 32'(mem_en), 32'd1);
        check("mis_mem_addr", 32'(mem_addr), 32'h1);
        check("mis_mem_wstrb", 32'(mem_wstrb), 32'b1111);
        collect("mis_st", 2);
`endif
        send(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'd0, bad);
        collect("mis_readback", 2 + LAT);

        // Back-to-back random traffic against the reference memory.
        n_rsp = 0;
        for (int n = 0; n < 20; n++) begin
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            send(we, size, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, bad);
            collect($sformatf("rnd%0d", n), bad ? 1 : (we ? 2 : 2 + LAT));
            n_rsp++;
        end
        check("rnd_responses", 32'(n_rsp), 32'd20);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
